sd_block_seq: RTL and testbench

SD_BLOCK_SEQ -- requirements
Module: sd_block_seq

---
 rtl/sd_block_seq.sv | 196 +++++++++++++++++++
 tb/tb_sd_block_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_seq.sv
// sd_block_seq: multi-sector SD block sequencer. Runs the init engine once,
// then accepts read/write burst commands and issues one request per sector
// to the block engines. The SPI lines are muxed to whichever engine owns them.
// A per-sector watchdog aborts a stuck burst with an err pulse.
// Optional feature macro: SD_SEQ_RETRY_EN (re-issue a timed-out sector up to
// MAX_RETRY times before giving up).
module sd_block_seq #(
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic             SD_clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_wr,
   input  logic [31:0]      cmd_sec,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             busy,
   output logic             init_done,
   output logic             done,
   output logic             err,
   input  logic             init_o,
   input  logic             write_o,
   input  logic             read_o,
   output logic             wr_req,
   output logic             rd_req,
   output logic [31:0]      wr_sec,
   output logic [31:0]      rd_sec,
   input  logic             SD_cs_i,
   input  logic             SD_cs_w,
   input  logic             SD_cs_r,
   input  logic             SD_datain_i,
   input  logic             SD_datain_w,
   input  logic             SD_datain_r,
   output logic             SD_cs,
   output logic             SD_datain
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
`ifdef SD_SEQ_RETRY_EN
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
`endif

   typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, GAP, FIN} state_t;

   state_t           state_q, state_d;
   logic             cur_wr_q, cur_wr_d;
   logic [31:0]      cur_sec_q, cur_sec_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
   logic             err_d;
   logic             flag;
   logic             cmd_ready_q, busy_q, init_done_q, done_q, err_q;
   logic             wr_req_q, rd_req_q;
   logic [31:0]      wr_sec_q, rd_sec_q;
`ifdef SD_SEQ_RETRY_EN
   logic [RTY_W-1:0] retry_q, retry_d;
`endif

   assign flag    = cur_wr_q ? write_o : read_o;
   assign tmo_inc = tmo_q + 1'b1;

   // Next-state and datapath: command latch, sector stepping, watchdog, retry
   always_comb begin
      state_d   = state_q;
      cur_wr_d  = cur_wr_q;
      cur_sec_d = cur_sec_q;
      remain_d  = remain_q;
      tmo_d     = tmo_q;
      err_d     = 1'b0;
`ifdef SD_SEQ_RETRY_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         INIT: if (init_o) state_d = IDLE;
         IDLE: begin
            if (cmd_valid) begin
               cur_wr_d  = cmd_wr;
               cur_sec_d = cmd_sec;
               remain_d  = cmd_cnt;
               state_d   = (cmd_cnt == '0) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            tmo_d = tmo_inc;
            // completion wins over a watchdog expiry in the same cycle
            if (flag) begin
               cur_sec_d = cur_sec_q + 32'd1;
               remain_d  = remain_q - 1'b1;
               state_d   = GAP;
`ifdef SD_SEQ_RETRY_EN
               retry_d   = '0;
`endif
            end else if (tmo_inc >= TMO_LAST) begin
`ifdef SD_SEQ_RETRY_EN
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = GAP;
               end else begin
                  retry_d  = '0;
                  remain_d = '0;
                  err_d    = 1'b1;
                  state_d  = IDLE;
               end
`else
               remain_d = '0;
               err_d    = 1'b1;
               state_d  = IDLE;
`endif
            end
         end
         GAP:     state_d = (remain_q == '0) ? FIN : ISSUE;
         FIN:     state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   // State and registered outputs, derived from the state being entered
   always_ff @(posedge SD_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         cur_wr_q    <= 1'b0;
         cur_sec_q   <= '0;
         remain_q    <= '0;
         tmo_q       <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         init_done_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wr_req_q    <= 1'b0;
         rd_req_q    <= 1'b0;
         wr_sec_q    <= '0;
         rd_sec_q    <= '0;
`ifdef SD_SEQ_RETRY_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cur_wr_q    <= cur_wr_d;
         cur_sec_q   <= cur_sec_d;
         remain_q    <= remain_d;
         tmo_q       <= tmo_d;
         cmd_ready_q <= (state_d == IDLE);
         busy_q      <= (state_d != IDLE) && (state_d != INIT);
         init_done_q <= (state_d != INIT);
         done_q      <= (state_q == FIN);
         err_q       <= err_d;
         wr_req_q    <= (state_d == ISSUE) && cur_wr_d;
         rd_req_q    <= (state_d == ISSUE) && !cur_wr_d;
         if ((state_d == ISSUE) && cur_wr_d)  wr_sec_q <= cur_sec_d;
         if ((state_d == ISSUE) && !cur_wr_d) rd_sec_q <= cur_sec_d;
`ifdef SD_SEQ_RETRY_EN
         retry_q     <= retry_d;
`endif
      end
   end

   // SPI mux: the owning engine drives the card, otherwise lines idle high
   always_comb begin
      SD_cs     = 1'b1;
      SD_datain = 1'b1;
      case (state_q)
         INIT: begin
            SD_cs     = SD_cs_i;
            SD_datain = SD_datain_i;
         end
         ISSUE, WAIT: begin
            SD_cs     = cur_wr_q ? SD_cs_w : SD_cs_r;
            SD_datain = cur_wr_q ? SD_datain_w : SD_datain_r;
         end
         default: begin
            SD_cs     = 1'b1;
            SD_datain = 1'b1;
         end
      endcase
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;
   assign done      = done_q;
   assign err       = err_q;
   assign wr_req    = wr_req_q;
   assign rd_req    = rd_req_q;
   assign wr_sec    = wr_sec_q;
   assign rd_sec    = rd_sec_q;

endmodule

// File: tb/tb_sd_block_seq.sv
// tb_sd_block_seq: scoreboard bench for sd_block_seq. Expected requests and
// done/err events are queued when a command is driven and popped when the
// DUT produces them. A small engine model answers requests after a set
// latency or never (stuck). Honours SD_SEQ_RETRY_EN for the retry count.
module tb_sd_block_seq;

   localparam int CNT_W = 8;
   localparam int TMO   = 50;
   localparam int MAXR  = 2;

   logic             SD_clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0, cmd_wr = 1'b0;
   logic [31:0]      cmd_sec = '0;
   logic [CNT_W-1:0] cmd_cnt = '0;
   logic             init_o = 1'b0, write_o = 1'b0, read_o = 1'b0;
   // distinct (cs,datain) per source: init 00, write 01, read 10, idle 11
   logic             SD_cs_i = 1'b0, SD_datain_i = 1'b0;
   logic             SD_cs_w = 1'b0, SD_datain_w = 1'b1;
   logic             SD_cs_r = 1'b1, SD_datain_r = 1'b0;
   logic             cmd_ready, busy, init_done, done, err;
   logic             wr_req, rd_req, SD_cs, SD_datain;
   logic [31:0]      wr_sec, rd_sec;

   sd_block_seq #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
      .SD_clk(SD_clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_sec(cmd_sec), .cmd_cnt(cmd_cnt),
      .busy(busy), .init_done(init_done), .done(done), .err(err),
      .init_o(init_o), .write_o(write_o), .read_o(read_o),
      .wr_req(wr_req), .rd_req(rd_req), .wr_sec(wr_sec), .rd_sec(rd_sec),
      .SD_cs_i(SD_cs_i), .SD_cs_w(SD_cs_w), .SD_cs_r(SD_cs_r),
      .SD_datain_i(SD_datain_i), .SD_datain_w(SD_datain_w), .SD_datain_r(SD_datain_r),
      .SD_cs(SD_cs), .SD_datain(SD_datain)
   );

   always #5 SD_clk = ~SD_clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] sec;
   } req_t;

   req_t exp_req[$];
   int   exp_evt[$];   // 1 = done, 2 = err

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_cyc = 0, done_cyc = 0, err_cyc = 0, last_req_cyc = 0;
   int evt_seen = 0, req_seen = 0;
   int eng_lat = 5;
   bit eng_stuck = 1'b0;
   int eng_cnt = 0;
   bit eng_wr = 1'b0;
   bit chk_mux = 1'b0;
   bit mux_wr = 1'b0;

   always @(posedge SD_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor + engine model, sampled on the falling edge
   always @(negedge SD_clk) begin
      write_o = 1'b0;
      read_o  = 1'b0;
      if (rst_n) begin
         if (wr_req || rd_req) begin
            automatic bit pend = (exp_req.size() != 0);
            check_eq("req_onehot", {63'd0, wr_req & rd_req}, 64'd0);
            check_eq("req_pending", {63'd0, pend}, 64'd1);
            if (pend) begin
               automatic req_t r = exp_req.pop_front();
               check_eq("req_kind", {63'd0, wr_req}, {63'd0, r.wr});
               check_eq("req_sec", {32'd0, (wr_req ? wr_sec : rd_sec)}, {32'd0, r.sec});
            end
            $display("req %s sec=%08h cycle=%0d", wr_req ? "WR" : "RD",
                     wr_req ? wr_sec : rd_sec, cyc);
            last_req_cyc = cyc;
            req_seen++;
            chk_mux = 1'b1;
            mux_wr  = wr_req;
            eng_wr  = wr_req;
            eng_cnt = eng_stuck ? 0 : eng_lat;
         end else begin
            if (chk_mux) begin
               chk_mux = 1'b0;
               check_eq("mux_cs", {63'd0, SD_cs}, {63'd0, ~mux_wr});
               check_eq("mux_din", {63'd0, SD_datain}, {63'd0, mux_wr});
            end
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  if (eng_wr) write_o = 1'b1;
                  else        read_o  = 1'b1;
               end
            end
         end
         if (done || err) begin
            automatic bit pend = (exp_evt.size() != 0);
            check_eq("done_err_excl", {63'd0, done & err}, 64'd0);
            check_eq("evt_pending", {63'd0, pend}, 64'd1);
            if (pend) begin
               automatic int code = exp_evt.pop_front();
               check_eq("evt_kind", err ? 64'd2 : 64'd1, 64'(code));
            end
            check_eq("evt_ready", {63'd0, cmd_ready}, 64'd1);
            check_eq("evt_busy", {63'd0, busy}, 64'd0);
            check_eq("evt_idle_mux", {62'd0, SD_cs, SD_datain}, 64'd3);
            if (err) err_cyc = cyc;
            else     done_cyc = cyc;
            $display("evt %s cycle=%0d", err ? "ERR" : "DONE", cyc);
            evt_seen++;
         end
      end
   end

   task automatic do_init();
      repeat (9) @(posedge SD_clk);
      #1;
      check_eq("init_pre_done", {63'd0, init_done}, 64'd0);
      check_eq("init_mux", {62'd0, SD_cs, SD_datain}, {62'd0, SD_cs_i, SD_datain_i});
      init_o = 1'b1;
      @(posedge SD_clk);
      #1;
      init_o = 1'b0;
      check_eq("init_done", {63'd0, init_done}, 64'd1);
      check_eq("init_ready", {63'd0, cmd_ready}, 64'd1);
      check_eq("init_busy", {63'd0, busy}, 64'd0);
   endtask

   task automatic send_cmd(input bit wr, input logic [31:0] sec, input logic [CNT_W-1:0] cnt);
      for (int i = 0; i < 200 && !cmd_ready; i++) begin
         @(posedge SD_clk);
         #1;
      end
      check_eq("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_sec   = sec;
      cmd_cnt   = cnt;
      acc_cyc   = cyc;
      $display("cmd %s sec=%08h cnt=%0d cycle=%0d", wr ? "WR" : "RD", sec, cnt, cyc);
      @(posedge SD_clk);
      #1;
      cmd_valid = 1'b0;
      check_eq("cmd_ready_drop", {63'd0, cmd_ready}, 64'd0);
   endtask

   task automatic wait_events(input int target, input int budget);
      for (int i = 0; i < budget && evt_seen < target; i++) @(posedge SD_clk);
      #1;
      check_eq("evt_count", 64'(evt_seen), 64'(target));
   endtask

   task automatic push_reqs(input bit wr, input logic [31:0] sec, input int n, input bit same);
      for (int i = 0; i < n; i++) begin
         automatic req_t r;
         r.wr  = wr;
         r.sec = same ? sec : sec + 32'(i);
         exp_req.push_back(r);
      end
   endtask

   initial begin
      int n_try;
      int req_target;
`ifdef SD_SEQ_RETRY_EN
      n_try = MAXR + 1;
`else
      n_try = 1;
`endif
      // reset state
      repeat (3) @(posedge SD_clk);
      #1;
      check_eq("rst_ready", {63'd0, cmd_ready}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_init_done", {63'd0, init_done}, 64'd0);
      check_eq("rst_done_err", {62'd0, done, err}, 64'd0);
      check_eq("rst_reqs", {62'd0, wr_req, rd_req}, 64'd0);
      check_eq("rst_secs", {wr_sec, rd_sec}, 64'd0);
      check_eq("rst_cs", {62'd0, SD_cs, SD_datain}, {62'd0, SD_cs_i, SD_datain_i});
      rst_n = 1'b1;
      do_init();

      // write burst, 3 sectors, engine latency 20
      eng_stuck = 1'b0;
      eng_lat   = 20;
      push_reqs(1'b1, 32'd100, 3, 1'b0);
      exp_evt.push_back(1);
      send_cmd(1'b1, 32'd100, 8'd3);
      wait_events(1, 300);

      // read burst crossing the 32-bit wrap
      eng_lat = 5;
      push_reqs(1'b0, 32'hFFFF_FFFE, 3, 1'b0);
      exp_evt.push_back(1);
      send_cmd(1'b0, 32'hFFFF_FFFE, 8'd3);
      wait_events(2, 100);

      // zero-length read: no request, done two cycles after accept
      exp_evt.push_back(1);
      send_cmd(1'b0, 32'd7, 8'd0);
      wait_events(3, 20);
      check_eq("cnt0_lat", 64'(done_cyc - acc_cyc), 64'd2);

      // completion on the very last watchdog cycle must win
      eng_lat = TMO - 1;
      push_reqs(1'b1, 32'd200, 1, 1'b0);
      exp_evt.push_back(1);
      send_cmd(1'b1, 32'd200, 8'd1);
      wait_events(4, 200);

      // stuck engine: timeout (with retries when enabled), err, back to idle
      eng_stuck = 1'b1;
      push_reqs(1'b0, 32'h55, n_try, 1'b1);
      exp_evt.push_back(2);
      send_cmd(1'b0, 32'h55, 8'd2);
      wait_events(5, 100 * (MAXR + 2));
      check_eq("tmo_lat", 64'(err_cyc - last_req_cyc), 64'(TMO));
      @(posedge SD_clk);
      #1;
      check_eq("post_err_ready", {63'd0, cmd_ready}, 64'd1);

      // reset in the middle of WAIT: abort silently, re-run init
      push_reqs(1'b0, 32'h77, 1, 1'b0);
      req_target = req_seen + 1;
      send_cmd(1'b0, 32'h77, 8'd2);
      for (int i = 0; i < 20 && req_seen < req_target; i++) @(posedge SD_clk);
      check_eq("mid_req_seen", 64'(req_seen), 64'(req_target));
      repeat (10) @(posedge SD_clk);
      #1;
      rst_n = 1'b0;
      #2;
      check_eq("mid_rst_ready", {63'd0, cmd_ready}, 64'd0);
      check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
      check_eq("mid_rst_init", {63'd0, init_done}, 64'd0);
      check_eq("mid_rst_mux", {62'd0, SD_cs, SD_datain}, {62'd0, SD_cs_i, SD_datain_i});
      repeat (5) @(posedge SD_clk);
      #1;
      rst_n = 1'b1;
      do_init();
      repeat (80) @(posedge SD_clk);
      #1;
      check_eq("no_extra_evt", 64'(evt_seen), 64'd5);
      check_eq("req_q_empty", 64'(exp_req.size()), 64'd0);
      check_eq("evt_q_empty", 64'(exp_evt.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
